cache_fill_ctrl: RTL and testbench
==================================

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 16, byte-independent word address width.
REQ-002 Parameter: DATA_W, default 16, word data width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: miss_req  input  1  level; request a line fill when high in IDLE.
REQ-006 Port: miss_addr  input  ADDR_W  word address of the missing word; bits [2:0] select the critical word.
REQ-007 Port: busy  output  1  high in every state except IDLE.
REQ-008 Port: mem_rd_req  output  1  read request to memory; held high until accepted by mem_rd_valid.
REQ-009 Port: mem_addr  output  ADDR_W  {line base [ADDR_W-1:3], word_ptr}.
REQ-010 Port: mem_rd_valid  input  1  read data valid; counted only while mem_rd_req is high.
REQ-011 Port: mem_rd_data  input  DATA_W  read data.
REQ-012 Port: word_addr  output  3  word index into the line, driving the 3-to-8 word-enable decoder.
REQ-013 Port: word_wr_en  output  1  one-cycle write strobe for word_addr/word_data.
REQ-014 Port: word_data  output  DATA_W  data to write into the line.
REQ-015 Port: crit_valid  output  1  one-cycle pulse coincident with the critical-word write.
REQ-016 Port: fill_done  output  1  one-cycle pulse after the eighth word write.

Function
REQ-017 States: IDLE, REQ, DONE; all outputs registered.
REQ-018 IDLE: when miss_req=1, capture line base = miss_addr[ADDR_W-1:3], word_ptr = miss_addr[2:0], count = 0, go to REQ next cycle.
REQ-019 REQ: mem_rd_req=1, mem_addr={base, word_ptr}; hold both stable until mem_rd_valid=1 is sampled.
REQ-020 On a sampled mem_rd_valid in REQ, the next cycle: word_wr_en=1, word_addr=word_ptr (the value before the increment), word_data=mem_rd_data as sampled.
REQ-021 Accept also advances word_ptr = (word_ptr+1) mod 8, wrapping 7->0, and increments count.
REQ-022 crit_valid=1 together with the word_wr_en of count 0 only.
REQ-023 Accept with count<7: stay in REQ; the new mem_addr appears on the cycle of the word_wr_en.
REQ-024 Accept with count=7: go to DONE; mem_rd_req=0 from the next cycle.
REQ-025 DONE: fill_done=1 for exactly one cycle, coincident with the eighth word_wr_en; next state IDLE.
REQ-026 Each fill issues exactly 8 reads, each word index exactly once, in wrap order starting at the critical word.
REQ-027 Minimum fill time with mem_rd_valid held high: 1 (IDLE) + 8 (REQ) cycles; fill_done 9 cycles after miss_req is sampled.
REQ-028 miss_req and miss_addr are ignored while busy=1; a miss_req still high in IDLE after DONE starts a new fill.
REQ-029 mem_rd_valid is ignored when mem_rd_req=0, including IDLE and DONE.
REQ-030 word_wr_en and fill_done are never high outside a fill; no two word_wr_en pulses have the same word_addr within one fill.

Reset
REQ-031 rst_n=0 asynchronously forces IDLE: busy, mem_rd_req, word_wr_en, crit_valid and fill_done = 0; mem_addr, word_addr, word_data and counters = 0.
REQ-032 Reset mid-fill aborts the fill with no fill_done; after release, the block waits in IDLE for a new miss_req.

Verification
REQ-033 miss_addr=0x0010, mem_rd_valid always 1 -> word_addr sequence 0..7 on 8 consecutive cycles; crit_valid with word 0; fill_done on the 8th write.
REQ-034 miss_addr=0x0015 -> mem_addr sequence 0x15,0x16,0x17,0x10,0x11,0x12,0x13,0x14; crit_valid with word_addr=5.
REQ-035 mem_rd_valid delayed 3 cycles per word -> mem_rd_req and mem_addr stay stable while waiting; 8 writes total; fill_done 33 cycles after the start.
REQ-036 miss_req pulsed with miss_addr=0x0040 during a fill of 0x0010 -> ignored; all writes use base 0x0010.
REQ-037 rst_n low after the 3rd word write -> all outputs 0 immediately; no fill_done; a later miss_req starts a clean 8-word fill.
REQ-038 mem_rd_valid=1 while in IDLE -> no word_wr_en and no state change.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller.
// On a miss, fetches an 8-word line from memory starting at the critical
// word and wrapping around the line, writing each returned word into the
// line buffer as it arrives. The critical word is flagged so the core can
// restart early, and completion is signalled with a single-cycle pulse.
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              busy,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [2:0]        word_addr,
    output logic              word_wr_en,
    output logic [DATA_W-1:0] word_data,
    output logic              crit_valid,
    output logic              fill_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-4:0]   base_reg;   // line base address, word index stripped
    logic [2:0]          ptr_reg;    // next word index to request
    logic [2:0]          count_reg;  // words already accepted in this fill

    // Next word index in wrap order; 3-bit arithmetic wraps 7 -> 0 naturally.
    logic [2:0] ptr_inc;
    assign ptr_inc = ptr_reg + 3'd1;

    // Fill sequencer: all outputs are registered here so the line buffer and
    // memory interface see glitch-free, edge-aligned signals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            base_reg   <= '0;
            ptr_reg    <= '0;
            count_reg  <= '0;
            busy       <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_addr   <= '0;
            word_addr  <= '0;
            word_wr_en <= 1'b0;
            word_data  <= '0;
            crit_valid <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            word_wr_en <= 1'b0;
            crit_valid <= 1'b0;
            fill_done  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (miss_req) begin
                        base_reg   <= miss_addr[ADDR_W-1:3];
                        ptr_reg    <= miss_addr[2:0];
                        count_reg  <= '0;
                        mem_addr   <= miss_addr;
                        mem_rd_req <= 1'b1;
                        busy       <= 1'b1;
                        state_reg  <= REQ;
                    end
                end

                REQ: begin
                    // mem_rd_req is always high in this state, so a valid
                    // here is a genuine acceptance of the outstanding read.
                    if (mem_rd_valid) begin
                        word_wr_en <= 1'b1;
                        word_addr  <= ptr_reg;
                        word_data  <= mem_rd_data;
                        crit_valid <= (count_reg == 3'd0);
                        ptr_reg    <= ptr_inc;
                        count_reg  <= count_reg + 3'd1;
                        mem_addr   <= {base_reg, ptr_inc};
                        if (count_reg == 3'd7) begin
                            // Last word: drop the request and flag completion
                            // in the same cycle as the final write.
                            mem_rd_req <= 1'b0;
                            fill_done  <= 1'b1;
                            state_reg  <= DONE;
                        end
                    end
                end

                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    busy       <= 1'b0;
                    mem_rd_req <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Testbench for cache_fill_ctrl: table of fill scenarios checked against a
// scoreboard of expected line writes, plus hand-written reset/idle sequences.
module tb_cache_fill_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst_n;
    logic              miss_req;
    logic [ADDR_W-1:0] miss_addr;
    logic              busy;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;
    logic [2:0]        word_addr;
    logic              word_wr_en;
    logic [DATA_W-1:0] word_data;
    logic              crit_valid;
    logic              fill_done;

    cache_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .busy         (busy),
        .mem_rd_req   (mem_rd_req),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .word_addr    (word_addr),
        .word_wr_en   (word_wr_en),
        .word_data    (word_data),
        .crit_valid   (crit_valid),
        .fill_done    (fill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One fill scenario: miss address, idle cycles before each valid,
    // whether to inject a foreign miss mid-fill, and write count at which
    // to assert reset (0 = never).
    typedef struct {
        logic [15:0] addr;
        int          wt;
        bit          ign;
        int          abort_at;
    } vec_t;

    typedef struct {
        logic [2:0]  wa;
        logic [15:0] data;
        logic [15:0] maddr;
        logic        crit;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Memory model contents: a scrambled function of the word address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},       {31'd0, busy},       32'd0);
        chk({tag, "_mem_rd_req"}, {31'd0, mem_rd_req}, 32'd0);
        chk({tag, "_word_wr_en"}, {31'd0, word_wr_en}, 32'd0);
        chk({tag, "_crit_valid"}, {31'd0, crit_valid}, 32'd0);
        chk({tag, "_fill_done"},  {31'd0, fill_done},  32'd0);
        chk({tag, "_mem_addr"},   {16'd0, mem_addr},   32'd0);
        chk({tag, "_word_addr"},  {29'd0, word_addr},  32'd0);
        chk({tag, "_word_data"},  {16'd0, word_data},  32'd0);
    endtask

    task automatic run_fill(input vec_t v);
        int   c;
        int   writes;
        int   wcnt;
        bit   done;
        exp_t e;
        logic [2:0]  wa;
        logic [15:0] ea;

        q.delete();
        for (int i = 0; i < 8; i++) begin
            wa = v.addr[2:0] + i[2:0];
            ea = {v.addr[15:3], wa};
            q.push_back('{wa, memf(ea), ea, (i == 0), (i == 7)});
        end

        @(negedge clk);
        miss_req     = 1'b1;
        miss_addr    = v.addr;
        mem_rd_valid = 1'b0;
        c = 0; writes = 0; wcnt = 0; done = 0;

        while (!done && c < 300) begin
            @(negedge clk);
            c++;
            miss_req = 1'b0;
            if (v.ign && c == 3) begin
                miss_req  = 1'b1;
                miss_addr = 16'h0040;
            end
            chk("busy_in_fill", {31'd0, busy}, 32'd1);
            if (word_wr_en) begin
                if (q.size() == 0) begin
                    chk("extra_write", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    writes++;
                    $display("fill %h: write #%0d word_addr=%0d data=%h crit=%0b done=%0b",
                             v.addr, writes, word_addr, word_data, crit_valid, fill_done);
                    chk("word_addr",  {29'd0, word_addr},  {29'd0, e.wa});
                    chk("word_data",  {16'd0, word_data},  {16'd0, e.data});
                    chk("crit_valid", {31'd0, crit_valid}, {31'd0, e.crit});
                    chk("fill_done",  {31'd0, fill_done},  {31'd0, e.last});
                end
            end else begin
                chk("no_write_crit", {31'd0, crit_valid}, 32'd0);
                chk("no_write_done", {31'd0, fill_done},  32'd0);
            end

            if (fill_done) begin
                done = 1;
                chk("fill_time", c, 1 + 8 * (v.wt + 1));
                chk("req_drop",  {31'd0, mem_rd_req}, 32'd0);
            end else if (q.size() > 0) begin
                chk("mem_rd_req", {31'd0, mem_rd_req}, 32'd1);
                chk("mem_addr",   {16'd0, mem_addr},   {16'd0, q[0].maddr});
            end

            if (v.abort_at != 0 && writes == v.abort_at) begin
                rst_n        = 1'b0;
                mem_rd_valid = 1'b0;
                miss_req     = 1'b0;
                #1;
                chk_all_zero("abort");
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("abort_no_done", {31'd0, fill_done},  32'd0);
                    chk("abort_no_wr",   {31'd0, word_wr_en}, 32'd0);
                end
                rst_n = 1'b1;
                q.delete();
                return;
            end

            if (wcnt == v.wt) begin
                mem_rd_valid = 1'b1;
                wcnt = 0;
            end else begin
                mem_rd_valid = 1'b0;
                wcnt++;
            end
            mem_rd_data = memf(mem_addr);
        end

        if (!done) chk("fill_timeout", 32'd0, 32'd1);
        chk("queue_empty", q.size(), 32'd0);
        chk("write_count", writes, 32'd8);
        // Valid may still be high in DONE; it must be ignored there.
        @(negedge clk);
        mem_rd_valid = 1'b0;
        chk("idle_busy",   {31'd0, busy},       32'd0);
        chk("idle_wr",     {31'd0, word_wr_en}, 32'd0);
        chk("idle_done",   {31'd0, fill_done},  32'd0);
        chk("idle_rd_req", {31'd0, mem_rd_req}, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'h0010, 0, 1'b0, 0};
        vecs[1] = '{16'h0015, 0, 1'b0, 0};
        vecs[2] = '{16'h0010, 3, 1'b0, 0};
        vecs[3] = '{16'h0010, 0, 1'b1, 0};
        vecs[4] = '{16'h0010, 1, 1'b0, 3};
        vecs[5] = '{16'h0010, 0, 1'b0, 0};
        vecs[6] = '{16'h123F, 2, 1'b0, 0};

        rst_n        = 1'b0;
        miss_req     = 1'b0;
        miss_addr    = '0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Valid while idle must not cause writes or leave IDLE.
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'hBEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("idle_valid_wr",   {31'd0, word_wr_en}, 32'd0);
            chk("idle_valid_busy", {31'd0, busy},       32'd0);
            chk("idle_valid_req",  {31'd0, mem_rd_req}, 32'd0);
        end
        mem_rd_valid = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_fill(vecs[i]);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
